// File: rtl/cs_window_param_if.sv
// Sample/result bundle for the CS sliding-window smoother.
// The master drives samples and controls; the slave returns results and fill level.
interface cs_window_param_if #(
    parameter int unsigned W = 8,
    parameter int unsigned K = 3
) ();
    logic           in_valid;
    logic [W-1:0]   X;
    logic           mode;
    logic           flush;
    logic           out_valid;
    logic [W+1:0]   Y;
    logic [K:0]     fill;

    modport master (
        output in_valid, X, mode, flush,
        input  out_valid, Y, fill
    );

    modport slave (
        input  in_valid, X, mode, flush,
        output out_valid, Y, fill
    );
endinterface

// File: rtl/cs_window_param.sv
// Sliding-window smoother over the last 2^K+1 samples.
// Y = (sum + N*Xsel) >> K, where Xsel is the nearest window sample on one side of the mean.
module cs_window_param #(
    parameter int unsigned W = 8,
    parameter int unsigned K = 3
) (
    input  logic              clk,
    input  logic              reset,
    cs_window_param_if.slave  bus
);
    localparam int          N       = (2 ** K) + 1;
    localparam int          SW      = W + K + 1;
    localparam logic [K:0]  FillMax = (K + 1)'(N);

    logic [W-1:0]  win_q [N];
    logic [W-1:0]  win_d [N];
    logic [K:0]    fill_q, fill_d;
    logic [W+1:0]  y_q, y_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  shift_win [N];
    logic [SW-1:0] sum;
    logic [SW-1:0] scaled;
    logic [W-1:0]  sel;
    logic [SW:0]   total;
    logic [W+1:0]  res_y;

    // Result datapath over the window as it will look after this accept.
    // Comparing N*X_i against the sum avoids dividing by N.
    always_comb begin
        shift_win[0] = bus.X;
        for (int i = 1; i < N; i++) begin
            shift_win[i] = win_q[i-1];
        end

        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SW'(shift_win[i]);
        end

        scaled = '0;
        sel    = bus.mode ? '1 : '0;
        for (int i = 0; i < N; i++) begin
            scaled = SW'(shift_win[i]) * SW'(N);
            if (!bus.mode) begin
                if ((scaled <= sum) && (shift_win[i] > sel)) begin
                    sel = shift_win[i];
                end
            end else begin
                if ((scaled >= sum) && (shift_win[i] < sel)) begin
                    sel = shift_win[i];
                end
            end
        end

        total = (SW + 1)'(sum) + (SW + 1)'(SW'(sel) * SW'(N));
        res_y = total[SW:K];
    end

    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        y_d         = y_q;
        out_valid_d = 1'b0;

        if (bus.flush) begin
            for (int i = 0; i < N; i++) begin
                win_d[i] = '0;
            end
            fill_d = '0;
            if (bus.in_valid) begin
                win_d[0] = bus.X;
                fill_d   = (K + 1)'(1);
            end
        end else if (bus.in_valid) begin
            win_d  = shift_win;
            fill_d = (fill_q == FillMax) ? fill_q : fill_q + (K + 1)'(1);
            if (fill_d == FillMax) begin
                out_valid_d = 1'b1;
                y_d         = res_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            fill_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            fill_q      <= fill_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Y         = y_q;
    assign bus.fill      = fill_q;
endmodule

// File: tb/tb_cs_window_param.sv
// Randomised bench for cs_window_param against a queue-based reference model,
// plus directed sequences with literal expected results.
module tb_cs_window_param;
    localparam int unsigned W = 8;
    localparam int unsigned K = 3;
    localparam int          N = (2 ** K) + 1;

    logic clk;
    logic reset;

    cs_window_param_if #(.W(W), .K(K)) bus ();

    cs_window_param #(.W(W), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: newest sample at the front of the queue.
    int unsigned mq[$];
    int unsigned m_y   = 0;
    int unsigned m_ov  = 0;
    int unsigned m_fill = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_result(input int unsigned m);
        int unsigned s;
        int unsigned xs;
        s = 0;
        foreach (mq[i]) s += mq[i];
        if (m == 0) begin
            xs = 0;
            foreach (mq[i]) if (N * mq[i] <= s && mq[i] > xs) xs = mq[i];
        end else begin
            xs = 1 << 30;
            foreach (mq[i]) if (N * mq[i] >= s && mq[i] < xs) xs = mq[i];
        end
        return (s + N * xs) / (2 ** K);
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] x, input logic m,
                        input logic fl, input logic rs);
        bus.in_valid = iv;
        bus.X        = x;
        bus.mode     = m;
        bus.flush    = fl;
        reset        = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_y  = 0;
            m_ov = 0;
        end else if (fl) begin
            mq.delete();
            if (iv) mq.push_front(int'(x));
            m_ov = 0;
        end else if (iv) begin
            mq.push_front(int'(x));
            if (mq.size() > N) void'(mq.pop_back());
            if (mq.size() == N) begin
                m_y  = model_result(int'(m));
                m_ov = 1;
            end else begin
                m_ov = 0;
            end
        end else begin
            m_ov = 0;
        end
        m_fill = mq.size();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(bus.out_valid), m_ov);
            chk("fill", 32'(bus.fill), m_fill);
            chk("Y", 32'(bus.Y), m_y);
        end
    end

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.X        = '0;
        bus.mode     = 1'b0;
        bus.flush    = 1'b0;
        reset        = 1'b1;

        do_reset();
        chk_en = 1'b1;
        chk("reset_Y", 32'(bus.Y), 32'h0);
        chk("reset_fill", 32'(bus.fill), 32'h0);
        chk("reset_ov", 32'(bus.out_valid), 32'h0);

        // Constant window fills after exactly N accepts.
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
            if (i < N - 1) chk("t1_early_ov", 32'(bus.out_valid), 32'h0);
        end
        chk("t1_ov", 32'(bus.out_valid), 32'h1);
        chk("t1_Y", 32'(bus.Y), 32'h024);

        // Ramp window, then slide by one.
        do_reset();
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("t2_Y_a", 32'(bus.Y), 32'h00B);
        step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        chk("t2_Y_b", 32'(bus.Y), 32'h00D);

        // Skewed window under both reference modes.
        do_reset();
        for (int i = 0; i < N - 1; i++) step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        chk("t3_mode0", 32'(bus.Y), 32'h001);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < N - 1; i++) step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        chk("t3_mode1", 32'(bus.Y), 32'h00B);

        // Maximum samples, then idle gaps hold state.
        do_reset();
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
            if (i == 4) begin
                step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                chk("t4_gap_ov", 32'(bus.out_valid), 32'h0);
                chk("t4_gap_fill", 32'(bus.fill), 32'h5);
            end
        end
        chk("t4_Y", 32'(bus.Y), 32'h23D);
        step(1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
        chk("t4_hold_ov", 32'(bus.out_valid), 32'h0);
        chk("t4_hold_Y", 32'(bus.Y), 32'h23D);
        chk("t4_hold_fill", 32'(bus.fill), 32'h9);

        // Flush with a same-cycle sample starts a new window.
        step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        chk("t5_fill", 32'(bus.fill), 32'h1);
        chk("t5_ov", 32'(bus.out_valid), 32'h0);
        chk("t5_Yhold", 32'(bus.Y), 32'h23D);
        for (int i = 0; i < N - 1; i++) step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        chk("t5_ov_end", 32'(bus.out_valid), 32'h1);
        chk("t5_Y", 32'(bus.Y), 32'h048);

        // Reset mid-fill.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("t6_fill5", 32'(bus.fill), 32'h5);
        step(1'b1, 8'h44, 1'b0, 1'b1, 1'b1);
        chk("t6_Y", 32'(bus.Y), 32'h0);
        chk("t6_fill", 32'(bus.fill), 32'h0);
        for (int i = 0; i < N; i++) begin
            step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
            if (i == N - 2) chk("t6_not_yet", 32'(bus.out_valid), 32'h0);
        end
        chk("t6_refill_ov", 32'(bus.out_valid), 32'h1);

        // Random traffic; narrow value ranges now and then to exercise duplicates.
        for (int i = 0; i < 3000; i++) begin
            logic          iv, m, fl, rs;
            logic [W-1:0]  x;
            iv = ($urandom_range(0, 3) != 0);
            m  = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 49) == 0);
            rs = ($urandom_range(0, 199) == 0);
            if ((i / 200) % 2 == 0) x = W'($urandom_range(0, 255));
            else                    x = W'($urandom_range(0, 3));
            step(iv, x, m, fl, rs);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
